note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Upstream stage of the square-wave tone generator. Walks a song table in
//  external sync ROM and converts each entry to a half-period count, a
//  note-on level and per-note/per-tick strobes. Its outputs drive the tone
//  generator's period input and the game's note-highway logic.
// PARAMETERS
//  ADDR_W      10         song ROM address width (max 2^ADDR_W entries)
//  TICK_DIV    6_250_000  CLK cycles per duration tick (1/16 note @120 BPM, 50 MHz)
//  GAP_CYCLES  500_000    silent CLK cycles after every note; 0 = no gap
// PORTS
//  CLK          in   1       system clock, 50 MHz
//  RESET_N      in   1       asynchronous, active-low reset
//  START        in   1       1-cycle pulse; honoured only in IDLE or DONE
//  PAUSE        in   1       level; freezes playback while high
//  SONG_ADDR    out  ADDR_W  registered ROM address
//  SONG_DATA    in   16      ROM word, valid 1 cycle after SONG_ADDR; [15:8]=note code, [7:0]=duration ticks
//  HALF_PERIOD  out  20      CLK cycles per half wave for current note
//  NOTE_ON      out  1       high while a non-rest note sounds
//  NOTE_STROBE  out  1       1-cycle pulse on the first PLAY cycle of every entry (rests included)
//  NOTE_CODE    out  8       code of current entry (0 = rest)
//  BEAT         out  1       1-cycle pulse at each tick-counter wrap in PLAY
//  MUS_DONE     out  1       level; high in DONE
// BEHAVIOUR
//  Reset (async assert; deassertion takes effect on next CLK):
//   state=IDLE, SONG_ADDR=0, HALF_PERIOD=0, NOTE_CODE=0, all 1-bit outputs 0, all counters 0.
//  States: IDLE, FETCH, WAIT, PLAY, GAP, DONE.
//   IDLE/DONE + START -> FETCH, SONG_ADDR=0, MUS_DONE=0.
//   FETCH -> WAIT unconditionally (ROM samples SONG_ADDR).
//   WAIT: capture SONG_DATA:
//    16'hFFFF -> DONE.
//    duration==0 -> skip: SONG_ADDR+1, FETCH, no strobe.
//    else -> PLAY; load dur_cnt=duration, tick_cnt=0; register NOTE_CODE
//    and HALF_PERIOD=pitch(code); NOTE_ON=(code valid); NOTE_STROBE=1 for 1 cycle.
//  START-to-PLAY latency: NOTE_ON high 2 cycles after the edge sampling START.
//  PLAY:
//   tick_cnt counts 0..TICK_DIV-1; at wrap, BEAT pulses and dur_cnt decrements.
//   On last tick wrap -> GAP (NOTE_ON=0) or, if GAP_CYCLES==0, directly to the
//   next fetch. PLAY lasts exactly duration*TICK_DIV cycles.
//  GAP: NOTE_ON=0, HALF_PERIOD held; after GAP_CYCLES cycles SONG_ADDR+1 -> FETCH.
//  Address wrap: entry at 2^ADDR_W-1 completing without end marker -> DONE
//   (no wrap to 0).
//  Pitch: code 36..95 (MIDI number) -> round(50e6/(2*f)), f=440*2^((code-69)/12).
//   Code 0 or outside 36..95 = rest: NOTE_ON=0, HALF_PERIOD holds previous value.
//  PAUSE=1 in PLAY/GAP: tick/gap/dur counters frozen, NOTE_ON forced 0, no BEAT.
//   On PAUSE=0, resume from the frozen count; NOTE_ON is restored if the note is valid.
//  PAUSE in IDLE/FETCH/WAIT/DONE: no effect.
//  START outside IDLE/DONE: ignored. START and PAUSE in the same cycle in IDLE:
//   START wins.
//  DONE: MUS_DONE=1, NOTE_ON=0, SONG_ADDR held; exit only via START or reset.
//  Reset mid-note: all outputs drop immediately (async).
// STRUCTURE
//  music_pkg: state enum, SONG_END=16'hFFFF, NOTE_MIN=36, NOTE_MAX=95,
//   HALF_PERIOD_W=20, song-entry struct {code[7:0], dur[7:0]}.
//  Sub-module note_pitch_lut: combinational code -> half-period table
//   (60 entries) plus valid flag.
//  Remainder is one FSM plus tick, dur and gap counters.
// TESTING (TICK_DIV=4, GAP_CYCLES=2, ADDR_W=4 unless noted)
//  1 ROM {0x4502,0xFFFF}, START -> NOTE_ON high 2 cycles later for 8 cycles;
//    HALF_PERIOD=56818; 2 BEATs; NOTE_STROBE once; 2 gap cycles; then MUS_DONE=1.
//  2 ROM {0x0001,0x3C01,0xFFFF} -> rest: STROBE=1, NOTE_ON=0 for 4 cycles;
//    then code 60: HALF_PERIOD=95556, NOTE_ON=1 for 4 cycles.
//  3 ROM {0x4500,0x4501,0xFFFF} -> zero-duration entry skipped;
//    exactly one STROBE; SONG_ADDR sequence 0,1,2.
//  4 PAUSE high 5 cycles mid-PLAY -> NOTE_ON=0, BEAT silent;
//    PLAY total = 8+5 cycles; HALF_PERIOD unchanged.
//  5 All 16 ROM words 0x4501 (no end marker) -> 16 STROBEs, then DONE;
//    SONG_ADDR never returns to 0. START in DONE restarts at address 0.
//  6 RESET_N low mid-PLAY between edges -> outputs 0 at once;
//    START during PLAY has no effect.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the song sequencer and its pitch table.
package music_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    PLAY  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [15:0] SONG_END      = 16'hFFFF;
  localparam logic [7:0]  NOTE_MIN      = 8'd36;
  localparam logic [7:0]  NOTE_MAX      = 8'd95;
  localparam int          HALF_PERIOD_W = 20;

  // One song-table word: note code in the high byte, duration ticks in the low byte.
  typedef struct packed {
    logic [7:0] code;
    logic [7:0] dur;
  } song_entry_t;

  // Codes outside the playable MIDI range are treated as rests.
  function automatic logic note_in_range(input logic [7:0] code);
    return (code >= NOTE_MIN) && (code <= NOTE_MAX);
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Song ROM read port between the sequencer and an external synchronous ROM.
// Protocol: no valid/ready pair; the master drives SONG_ADDR from a register
// and the slave returns SONG_DATA for that address exactly one clock later.
interface note_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] SONG_ADDR;
  logic [15:0]       SONG_DATA;

  modport master (output SONG_ADDR, input SONG_DATA);
  modport slave  (input SONG_ADDR, output SONG_DATA);
endinterface

// File: rtl/note_pitch_lut.sv
// Combinational MIDI code -> half-period table, round(25e6 / f) for a 50 MHz clock.
module note_pitch_lut
  import music_pkg::*;
(
  input  logic [7:0]               code,
  output logic [HALF_PERIOD_W-1:0] half_period,
  output logic                     valid
);

  // Table lookup; out-of-range codes return 0 and valid=0.
  always_comb begin
    valid       = note_in_range(code);
    half_period = '0;
    case (code)
      8'd36: half_period = 20'd382226;  8'd37: half_period = 20'd360773;
      8'd38: half_period = 20'd340524;  8'd39: half_period = 20'd321412;
      8'd40: half_period = 20'd303373;  8'd41: half_period = 20'd286346;
      8'd42: half_period = 20'd270274;  8'd43: half_period = 20'd255105;
      8'd44: half_period = 20'd240787;  8'd45: half_period = 20'd227273;
      8'd46: half_period = 20'd214517;  8'd47: half_period = 20'd202477;
      8'd48: half_period = 20'd191113;  8'd49: half_period = 20'd180386;
      8'd50: half_period = 20'd170262;  8'd51: half_period = 20'd160706;
      8'd52: half_period = 20'd151686;  8'd53: half_period = 20'd143173;
      8'd54: half_period = 20'd135137;  8'd55: half_period = 20'd127553;
      8'd56: half_period = 20'd120394;  8'd57: half_period = 20'd113636;
      8'd58: half_period = 20'd107258;  8'd59: half_period = 20'd101238;
      8'd60: half_period = 20'd95556;   8'd61: half_period = 20'd90193;
      8'd62: half_period = 20'd85131;   8'd63: half_period = 20'd80353;
      8'd64: half_period = 20'd75843;   8'd65: half_period = 20'd71586;
      8'd66: half_period = 20'd67569;   8'd67: half_period = 20'd63776;
      8'd68: half_period = 20'd60197;   8'd69: half_period = 20'd56818;
      8'd70: half_period = 20'd53629;   8'd71: half_period = 20'd50619;
      8'd72: half_period = 20'd47778;   8'd73: half_period = 20'd45097;
      8'd74: half_period = 20'd42566;   8'd75: half_period = 20'd40177;
      8'd76: half_period = 20'd37922;   8'd77: half_period = 20'd35793;
      8'd78: half_period = 20'd33784;   8'd79: half_period = 20'd31888;
      8'd80: half_period = 20'd30098;   8'd81: half_period = 20'd28409;
      8'd82: half_period = 20'd26815;   8'd83: half_period = 20'd25310;
      8'd84: half_period = 20'd23889;   8'd85: half_period = 20'd22548;
      8'd86: half_period = 20'd21283;   8'd87: half_period = 20'd20088;
      8'd88: half_period = 20'd18961;   8'd89: half_period = 20'd17897;
      8'd90: half_period = 20'd16892;   8'd91: half_period = 20'd15944;
      8'd92: half_period = 20'd15049;   8'd93: half_period = 20'd14205;
      8'd94: half_period = 20'd13407;   8'd95: half_period = 20'd12655;
      default: half_period = '0;
    endcase
  end

endmodule

// File: rtl/note_sequencer.sv
// Walks the song table in ROM and turns each entry into a half-period,
// note-on level, per-entry strobe and per-tick beat for the tone generator.
module note_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int TICK_DIV   = 6_250_000,
  parameter int GAP_CYCLES = 500_000
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     START,
  input  logic                     PAUSE,
  note_sequencer_if.master         rom,
  output logic [HALF_PERIOD_W-1:0] HALF_PERIOD,
  output logic                     NOTE_ON,
  output logic                     NOTE_STROBE,
  output logic [7:0]               NOTE_CODE,
  output logic                     BEAT,
  output logic                     MUS_DONE,
  output state_t                   STATE_DBG
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [TICK_W-1:0]        tick_q, tick_d;
  logic [7:0]               dur_q, dur_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [7:0]               code_q, code_d;
  logic [HALF_PERIOD_W-1:0] half_q, half_d;
  logic                     valid_q, valid_d;
  logic                     strobe_q, strobe_d;
  logic                     advance;

  song_entry_t              entry;
  logic [HALF_PERIOD_W-1:0] lut_half;
  logic                     lut_valid;

  assign entry = song_entry_t'(rom.SONG_DATA);

  note_pitch_lut u_lut (
    .code        (entry.code),
    .half_period (lut_half),
    .valid       (lut_valid)
  );

  // State and counter registers; reset clears every output source at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      tick_q   <= '0;
      dur_q    <= '0;
      gap_q    <= '0;
      code_q   <= '0;
      half_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tick_q   <= tick_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
      code_q   <= code_d;
      half_q   <= half_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  // Next-state, counter and note-register logic; PAUSE only freezes PLAY/GAP.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tick_d   = tick_q;
    dur_d    = dur_q;
    gap_d    = gap_q;
    code_d   = code_q;
    half_d   = half_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    advance  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (START) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if (rom.SONG_DATA == SONG_END) begin
          state_d = DONE;
        end else if (entry.dur == 8'd0) begin
          advance = 1'b1;
        end else begin
          state_d  = PLAY;
          dur_d    = entry.dur;
          tick_d   = '0;
          code_d   = entry.code;
          valid_d  = lut_valid;
          strobe_d = 1'b1;
          // A rest keeps the previous pitch so the tone generator sees no glitch.
          if (lut_valid) half_d = lut_half;
        end
      end
      PLAY: begin
        if (!PAUSE) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            dur_d  = dur_q - 8'd1;
            if (dur_q == 8'd1) begin
              if (GAP_CYCLES == 0) begin
                advance = 1'b1;
              end else begin
                state_d = GAP;
                gap_d   = '0;
              end
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (!PAUSE) begin
          if (gap_q == GAP_LAST) advance = 1'b1;
          else gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Moving on from the last table slot ends the song instead of wrapping.
    if (advance) begin
      if (addr_q == ADDR_LAST) begin
        state_d = DONE;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = FETCH;
      end
    end
  end

  assign rom.SONG_ADDR = addr_q;
  assign HALF_PERIOD   = half_q;
  assign NOTE_CODE     = code_q;
  assign NOTE_STROBE   = strobe_q;
  assign NOTE_ON       = (state_q == PLAY) && valid_q && !PAUSE;
  assign BEAT          = (state_q == PLAY) && !PAUSE && (tick_q == TICK_LAST);
  assign MUS_DONE      = (state_q == DONE);
  assign STATE_DBG     = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a small synchronous ROM model.
module tb_note_sequencer;
  import music_pkg::*;

  logic                     CLK;
  logic                     RESET_N;
  logic                     START;
  logic                     PAUSE;
  logic [HALF_PERIOD_W-1:0] HALF_PERIOD;
  logic                     NOTE_ON;
  logic                     NOTE_STROBE;
  logic [7:0]               NOTE_CODE;
  logic                     BEAT;
  logic                     MUS_DONE;
  state_t                   STATE_DBG;

  note_sequencer_if #(.ADDR_W(4)) bus ();

  note_sequencer #(.ADDR_W(4), .TICK_DIV(4), .GAP_CYCLES(2)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .START       (START),
    .PAUSE       (PAUSE),
    .rom         (bus),
    .HALF_PERIOD (HALF_PERIOD),
    .NOTE_ON     (NOTE_ON),
    .NOTE_STROBE (NOTE_STROBE),
    .NOTE_CODE   (NOTE_CODE),
    .BEAT        (BEAT),
    .MUS_DONE    (MUS_DONE),
    .STATE_DBG   (STATE_DBG)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // synchronous ROM model, one cycle read latency
  logic [15:0] rom_mem [16];
  always @(posedge CLK) bus.SONG_DATA <= rom_mem[bus.SONG_ADDR];

  int n_vec = 0;
  int n_mis = 0;

  int first_on, on_cnt, strobe_cnt, first_strobe, beat_cnt, play_cnt, gap_cnt, first_done;
  logic [19:0] hp_first, hp_last;
  logic [7:0]  code_first;
  logic [3:0]  addr_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    for (int i = 0; i < 16; i++) rom_mem[i] = 16'hFFFF;
    rom_mem[0] = w0;
    rom_mem[1] = w1;
    rom_mem[2] = w2;
  endtask

  // Pulses START at c=0 (and optionally again at c=s2), holds PAUSE for
  // c in [p_from, p_from+p_len), and gathers per-cycle statistics for c=1..ncyc.
  task automatic play_song(input int ncyc, input int p_from, input int p_len, input int s2);
    first_on = 0; on_cnt = 0; strobe_cnt = 0; first_strobe = 0; beat_cnt = 0;
    play_cnt = 0; gap_cnt = 0; first_done = 0; hp_first = '0; hp_last = '0;
    code_first = '0;
    addr_log.delete();
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge CLK);
      START = (c == 0) || (c == s2);
      PAUSE = (c >= p_from) && (c < p_from + p_len);
      #1;
      if (c > 0) begin
        if (NOTE_ON && first_on == 0) first_on = c;
        if (NOTE_ON) on_cnt++;
        if (NOTE_STROBE) begin
          strobe_cnt++;
          if (strobe_cnt == 1) begin
            first_strobe = c;
            hp_first     = HALF_PERIOD;
            code_first   = NOTE_CODE;
          end
          hp_last = HALF_PERIOD;
        end
        if (BEAT) beat_cnt++;
        if (STATE_DBG == PLAY) play_cnt++;
        if (STATE_DBG == GAP) gap_cnt++;
        if (MUS_DONE && first_done == 0) first_done = c;
        if (addr_log.size() == 0 || addr_log[$] != bus.SONG_ADDR) addr_log.push_back(bus.SONG_ADDR);
      end
    end
    START = 1'b0;
    PAUSE = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    PAUSE   = 1'b0;
    load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF);

    // reset state
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_state", 32'(STATE_DBG), 32'(IDLE));
    chk("rst_addr", 32'(bus.SONG_ADDR), 32'd0);
    chk("rst_hp", 32'(HALF_PERIOD), 32'd0);
    chk("rst_code", 32'(NOTE_CODE), 32'd0);
    chk("rst_bits", {28'd0, NOTE_ON, NOTE_STROBE, BEAT, MUS_DONE}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // single A4, two ticks, then end marker
    load_rom(16'h4502, 16'hFFFF, 16'hFFFF);
    play_song(20, -1, 0, -1);
    chk("t1_first_on", first_on, 32'd3);
    chk("t1_on_cnt", on_cnt, 32'd8);
    chk("t1_hp", 32'(hp_first), 32'd56818);
    chk("t1_code", 32'(code_first), 32'h45);
    chk("t1_strobes", strobe_cnt, 32'd1);
    chk("t1_strobe_at", first_strobe, 32'd3);
    chk("t1_beats", beat_cnt, 32'd2);
    chk("t1_gap", gap_cnt, 32'd2);
    chk("t1_done_at", first_done, 32'd15);
    chk("t1_done_addr", 32'(bus.SONG_ADDR), 32'd1);
    chk("t1_done_on", 32'(NOTE_ON), 32'd0);

    // PAUSE for 5 cycles starting on a beat cycle
    play_song(24, 6, 5, -1);
    chk("t4_play_len", play_cnt, 32'd13);
    chk("t4_on_cnt", on_cnt, 32'd8);
    chk("t4_beats", beat_cnt, 32'd2);
    chk("t4_hp", 32'(HALF_PERIOD), 32'd56818);
    chk("t4_done_at", first_done, 32'd20);

    // rest entry followed by middle C
    load_rom(16'h0001, 16'h3C01, 16'hFFFF);
    play_song(24, -1, 0, -1);
    chk("t2_strobes", strobe_cnt, 32'd2);
    chk("t2_rest_code", 32'(code_first), 32'd0);
    chk("t2_rest_hp", 32'(hp_first), 32'd56818);
    chk("t2_first_on", first_on, 32'd11);
    chk("t2_on_cnt", on_cnt, 32'd4);
    chk("t2_play_len", play_cnt, 32'd8);
    chk("t2_hp_c60", 32'(hp_last), 32'd95556);
    chk("t2_code_c60", 32'(NOTE_CODE), 32'h3C);
    chk("t2_done_at", first_done, 32'd19);

    // zero-duration skip, START together with PAUSE from DONE
    load_rom(16'h4500, 16'h4501, 16'hFFFF);
    play_song(18, 0, 4, -1);
    chk("t3_strobes", strobe_cnt, 32'd1);
    chk("t3_strobe_at", first_strobe, 32'd5);
    chk("t3_addr_n", addr_log.size(), 32'd3);
    chk("t3_addr0", 32'(addr_log[0]), 32'd0);
    chk("t3_addr1", 32'(addr_log[1]), 32'd1);
    chk("t3_addr2", 32'(addr_log[2]), 32'd2);
    chk("t3_done_at", first_done, 32'd13);

    // full table without end marker
    for (int i = 0; i < 16; i++) rom_mem[i] = 16'h4501;
    play_song(135, -1, 0, -1);
    chk("t5_strobes", strobe_cnt, 32'd16);
    chk("t5_on_cnt", on_cnt, 32'd64);
    chk("t5_addr_n", addr_log.size(), 32'd16);
    chk("t5_addr_last", 32'(addr_log[15]), 32'd15);
    chk("t5_done_at", first_done, 32'd129);
    chk("t5_hold_addr", 32'(bus.SONG_ADDR), 32'd15);
    play_song(3, -1, 0, -1);
    chk("t5_restart_addr", 32'(addr_log[0]), 32'd0);
    chk("t5_restart_done", 32'(MUS_DONE), 32'd0);
    chk("t5_restart_strobe", first_strobe, 32'd3);

    // START during PLAY ignored, then asynchronous reset mid-note
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    load_rom(16'h4502, 16'hFFFF, 16'hFFFF);
    play_song(6, -1, 0, 4);
    chk("t6_state", 32'(STATE_DBG), 32'(PLAY));
    chk("t6_on", 32'(NOTE_ON), 32'd1);
    chk("t6_beat", 32'(BEAT), 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t6_rst_state", 32'(STATE_DBG), 32'(IDLE));
    chk("t6_rst_bits", {28'd0, NOTE_ON, NOTE_STROBE, BEAT, MUS_DONE}, 32'd0);
    chk("t6_rst_hp", 32'(HALF_PERIOD), 32'd0);
    chk("t6_rst_code", 32'(NOTE_CODE), 32'd0);
    chk("t6_rst_addr", 32'(bus.SONG_ADDR), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("t6_idle_after", 32'(STATE_DBG), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
